// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM for a multicycle MIPS-subset datapath
// (lw, sw, R-type add/sub/and/or/slt, beq, addi, j). One instruction is
// walked through FETCH/DECODE and its execution states. Memory accesses
// stretch while mem_ready is low.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   opcode      in   [5:0] instruction[31:26]
//   funct       in   [5:0] instruction[5:0]
//   zero        in   ALU zero flag, used in BRANCH
//   mem_ready   in   memory access completes in the cycle it is 1
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca
//               out  datapath controls
//   alusrcb     out  [1:0] 00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc       out  [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   alucontrol  out  [2:0] 010 add, 110 sub, 000 and, 001 or, 111 slt
//   pcen        out  PC write enable
//   instr_done  out  pulse in the last cycle of each instruction
//   illegal     out  pulse when DECODE sees an unsupported opcode
//   state       out  [3:0] current state (debug)
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_done;
    logic       w_illegal;

    // True for every opcode DECODE knows how to dispatch.
    function automatic logic is_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU decoder: aluop selects add / sub / funct-driven operation.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] fn);
        logic [2:0] ctl;
        case (aluop)
            2'b01: ctl = 3'b110;
            2'b10: begin
                case (fn)
                    6'b100000: ctl = 3'b010;
                    6'b100010: ctl = 3'b110;
                    6'b100100: ctl = 3'b000;
                    6'b100101: ctl = 3'b001;
                    6'b101010: ctl = 3'b111;
                    default:   ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b010;
        endcase
        return ctl;
    endfunction

    // State register; reset drops straight to FETCH without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH: begin
                if (mem_ready) w_next_state = DECODE;
                else           w_next_state = FETCH;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = MEMADR;
                    OP_RTYPE:     w_next_state = EXECUTE;
                    OP_BEQ:       w_next_state = BRANCH;
                    OP_ADDI:      w_next_state = ADDIEX;
                    OP_J:         w_next_state = JUMP;
                    default:      w_next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_SW) w_next_state = MEMWR;
                else                 w_next_state = MEMRD;
            end
            MEMRD: begin
                if (mem_ready) w_next_state = MEMWB;
                else           w_next_state = MEMRD;
            end
            MEMWR: begin
                if (mem_ready) w_next_state = FETCH;
                else           w_next_state = MEMWR;
            end
            EXECUTE: w_next_state = ALUWB;
            ADDIEX:  w_next_state = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: w_next_state = FETCH;
            default: w_next_state = FETCH;
        endcase
    end

    // Per-state control decode; anything not set stays 0.
    always_comb begin
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsrc    = 2'b00;
        w_aluop    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_alusrcb = 2'b01;
                w_pcwrite = 1'b1;
            end
            DECODE: begin
                w_alusrcb = 2'b11;
                if (!is_supported(opcode)) begin
                    w_illegal = 1'b1;
                    w_done    = 1'b1;
                end else begin
                    w_illegal = 1'b0;
                    w_done    = 1'b0;
                end
            end
            MEMADR, ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            MEMRD: w_iord = 1'b1;
            MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            MEMWR: begin
                // Held for every wait cycle; the instruction ends with the handshake.
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = mem_ready;
            end
            EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
    end

    // Write strobes are gated by rst_n so nothing commits while reset is held.
    // The FETCH PC increment and IR load only happen once memory delivers.
    assign pcen       = rst_n & ((w_pcwrite & ((r_state != FETCH) | mem_ready))
                                 | (w_branch & zero));
    assign irwrite    = rst_n & w_irwrite & mem_ready;
    assign regwrite   = rst_n & w_regwrite;
    assign memwrite   = rst_n & w_memwrite;
    assign instr_done = rst_n & w_done;
    assign illegal    = rst_n & w_illegal;

    assign iord       = w_iord;
    assign regdst     = w_regdst;
    assign memtoreg   = w_memtoreg;
    assign alusrca    = w_alusrca;
    assign alusrcb    = w_alusrcb;
    assign pcsrc      = w_pcsrc;
    assign alucontrol = alu_decode(w_aluop, funct);
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench. A per-instruction reference model (list of states the
// instruction visits, with memory states waiting on mem_ready) predicts every
// output each cycle; output values come from per-signal rules.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, instr_done, illegal;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    int   plan[$];
    int   pidx;
    logic zero_v;
    logic last_done;
    logic last_mw;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic legal_op(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        logic [2:0] r;
        case (fn)
            6'b100000: r = 3'b010;
            6'b100010: r = 3'b110;
            6'b100100: r = 3'b000;
            6'b100101: r = 3'b001;
            6'b101010: r = 3'b111;
            default:   r = 3'b000;
        endcase
        return r;
    endfunction

    // Expected output word, one rule per signal.
    // Packing: iord memwrite irwrite regdst memtoreg regwrite alusrca
    //          alusrcb pcsrc alucontrol pcen instr_done illegal state
    function automatic logic [20:0] exp_vec(input int st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z,
                                            input logic mr, input logic rs);
        logic e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_done, e_ill;
        logic [1:0] e_asb, e_pcs;
        logic [2:0] e_alu;
        logic [3:0] e_st;
        if (!rs) st = 0;
        e_st   = st[3:0];
        e_iord = (st == 3) || (st == 5);
        e_mw   = (st == 5);
        e_ir   = (st == 0) && mr;
        e_rd   = (st == 7);
        e_m2r  = (st == 4);
        e_rw   = (st == 4) || (st == 7) || (st == 10);
        e_asa  = (st == 2) || (st == 6) || (st == 8) || (st == 9);
        e_asb  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 :
                 ((st == 2) || (st == 9)) ? 2'b10 : 2'b00;
        e_pcs  = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
        e_alu  = (st == 6) ? rtype_alu(fn) : (st == 8) ? 3'b110 : 3'b010;
        e_pcen = ((st == 0) && mr) || (st == 11) || ((st == 8) && z);
        e_ill  = (st == 1) && !legal_op(op);
        e_done = (st == 4) || (st == 7) || (st == 8) || (st == 10) ||
                 (st == 11) || ((st == 5) && mr) || e_ill;
        if (!rs) begin
            e_ir = 1'b0; e_pcen = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
            e_done = 1'b0; e_ill = 1'b0;
        end else begin
            e_ir = e_ir;
        end
        return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_asb, e_pcs,
                e_alu, e_pcen, e_done, e_ill, e_st};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, pcen, instr_done, illegal, state};
    endfunction

    task automatic check_vec(input string tag, input logic [20:0] exp);
        logic [20:0] got;
        got = dut_vec();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: outputs got=%h expected=%h (state got=%0d exp=%0d)",
                     tag, got, exp, got[3:0], exp[3:0]);
        end
    endtask

    // Load a new instruction into the model: the list of states it visits.
    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero_v = z;
        plan.delete();
        plan.push_back(0);
        plan.push_back(1);
        case (op)
            6'b100011: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
            6'b101011: begin plan.push_back(2); plan.push_back(5); end
            6'b000000: begin plan.push_back(6); plan.push_back(7); end
            6'b000100: plan.push_back(8);
            6'b001000: begin plan.push_back(9); plan.push_back(10); end
            6'b000010: plan.push_back(11);
            default:   plan.push_back(1);
        endcase
        if (!legal_op(op)) void'(plan.pop_back());
        pidx = 0;
    endtask

    // One clock: drive, compare at the falling edge, advance the model.
    task automatic tick(input logic mr, input string tag);
        int st;
        mem_ready = mr;
        zero      = zero_v;
        @(negedge clk);
        st = (pidx < plan.size()) ? plan[pidx] : 0;
        check_vec(tag, exp_vec(st, opcode, funct, zero_v, mr, 1'b1));
        last_done = instr_done;
        last_mw   = memwrite;
        @(posedge clk);
        #1;
        if (!((st == 0) || (st == 3) || (st == 5)) || mr) pidx++;
    endtask

    // Run one instruction with mem_ready=1 and measure its cycle count.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int cpi, input string tag);
        int got;
        got = 0;
        start_instr(op, fn, z);
        for (int c = 1; c <= 20; c++) begin
            tick(1'b1, tag);
            if (last_done) begin
                got = c;
                break;
            end
        end
        checks++;
        if (got != cpi) begin
            failures++;
            $display("FAIL cpi_%s: cycles got=%0d expected=%0d", tag, got, cpi);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cpi;
        string      name;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int mw_cnt;
        logic [5:0] rop, rfn;
        logic [5:0] fns[6];
        logic [5:0] ops[6];

        tbl[0]  = '{6'b100011, 6'b000000, 1'b0, 5, "lw"};
        tbl[1]  = '{6'b101011, 6'b000000, 1'b0, 4, "sw"};
        tbl[2]  = '{6'b000000, 6'b100010, 1'b0, 4, "r_sub"};
        tbl[3]  = '{6'b000000, 6'b101010, 1'b0, 4, "r_slt"};
        tbl[4]  = '{6'b000000, 6'b100000, 1'b0, 4, "r_add"};
        tbl[5]  = '{6'b000000, 6'b100100, 1'b0, 4, "r_and"};
        tbl[6]  = '{6'b000000, 6'b100101, 1'b0, 4, "r_or"};
        tbl[7]  = '{6'b000000, 6'b000111, 1'b0, 4, "r_other"};
        tbl[8]  = '{6'b001000, 6'b000000, 1'b0, 4, "addi"};
        tbl[9]  = '{6'b000100, 6'b000000, 1'b1, 3, "beq_taken"};
        tbl[10] = '{6'b000100, 6'b000000, 1'b0, 3, "beq_not"};
        tbl[11] = '{6'b000010, 6'b000000, 1'b1, 3, "j"};
        tbl[12] = '{6'b111111, 6'b000000, 1'b0, 2, "illegal"};
        tbl[13] = '{6'b010101, 6'b100000, 1'b1, 2, "illegal2"};

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};

        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b000000;
        zero = 1'b1; zero_v = 1'b1; last_done = 1'b0; last_mw = 1'b0;
        plan.delete(); pidx = 0;

        // Reset held: FETCH values, write strobes low even with mem_ready=1.
        #12;
        check_vec("reset_hold", exp_vec(0, opcode, funct, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        check_vec("reset_hold_edge", exp_vec(0, opcode, funct, zero, 1'b1, 1'b0));
        rst_n = 1'b1;

        // Table of single instructions with memory always ready.
        foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].cpi, tbl[i].name);

        // sw with three wait cycles in MEMWR: memwrite held four cycles.
        start_instr(6'b101011, 6'b000000, 1'b0);
        tick(1'b1, "sw_wait_fetch");
        tick(1'b1, "sw_wait_decode");
        tick(1'b1, "sw_wait_memadr");
        mw_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, "sw_wait_stall");
            if (last_mw) mw_cnt++;
        end
        tick(1'b1, "sw_wait_done");
        if (last_mw) mw_cnt++;
        checks++;
        if (mw_cnt != 4) begin
            failures++;
            $display("FAIL sw_memwrite_len: cycles got=%0d expected=4", mw_cnt);
        end

        // FETCH stalled by memory: state holds, no PC or IR write.
        start_instr(6'b000010, 6'b000000, 1'b0);
        tick(1'b0, "fetch_stall1");
        tick(1'b0, "fetch_stall2");
        tick(1'b1, "fetch_go");
        tick(1'b1, "j_decode");
        tick(1'b1, "j_jump");

        // Reset pulled mid-cycle while in MEMRD: immediate FETCH, no regwrite.
        start_instr(6'b100011, 6'b000000, 1'b0);
        tick(1'b1, "rst_lw_fetch");
        tick(1'b1, "rst_lw_decode");
        tick(1'b1, "rst_lw_memadr");
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rst_async", exp_vec(0, opcode, funct, zero, 1'b1, 1'b0));
        @(posedge clk); #1;
        check_vec("rst_async_edge", exp_vec(0, opcode, funct, zero, 1'b1, 1'b0));
        rst_n = 1'b1;
        run_instr(6'b100011, 6'b000000, 1'b0, 5, "lw_after_rst");

        // Randomized instructions and memory latency against the model.
        for (int n = 0; n < 250; n++) begin
            int sel;
            int cyc;
            sel = $urandom_range(0, 6);
            if (sel == 6) begin
                rop = 6'($urandom_range(0, 63));
                while (legal_op(rop)) rop = 6'($urandom_range(0, 63));
            end else begin
                rop = ops[sel];
            end
            rfn = fns[$urandom_range(0, 5)];
            start_instr(rop, rfn, 1'($urandom_range(0, 1)));
            cyc = 0;
            while ((pidx < plan.size()) && (cyc < 60)) begin
                tick(($urandom_range(0, 3) != 0), "random");
                cyc++;
            end
            if (pidx < plan.size()) begin
                checks++;
                failures++;
                $display("FAIL random_timeout: instr %0d unfinished got=%0d cycles expected<60", n, cyc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
